// File: rtl/lu_pkg.sv
// Shared types for the logic-unit issue stage: ctl width and the queued command bundle.
package lu_pkg;
  localparam int LU_CTL_W = 3;
  localparam int LU_WIDTH = 32;

  typedef struct packed {
    logic [LU_CTL_W-1:0] ctl;
    logic [LU_WIDTH-1:0] a;
    logic [LU_WIDTH-1:0] b;
  } lu_cmd_t;

  localparam int LU_CMD_W = $bits(lu_cmd_t);
endpackage

// File: rtl/lu_cmd_fifo.sv
// Small synchronous FIFO holding packed lu_cmd_t entries; head is read combinationally.
module lu_cmd_fifo
  import lu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = LU_CMD_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !rd_en)      count_d = count_q + (AW+1)'(1);
    else if (rd_en && !wr_en) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/lu_issue_queue.sv
// Issue stage in front of the combinational logic unit: command FIFO, result register, handshake.
// Optional LU_ISSUE_STATS_EN adds issued_cnt / stall_cnt outputs.
module lu_issue_queue
  import lu_pkg::*;
#(
  parameter int WIDTH = LU_WIDTH,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [WIDTH-1:0]    cmd_a,
  input  logic [WIDTH-1:0]    cmd_b,
  input  logic [LU_CTL_W-1:0] cmd_ctl,
  output logic [WIDTH-1:0]    lu_a,
  output logic [WIDTH-1:0]    lu_b,
  output logic [LU_CTL_W-1:0] lu_ctl,
  input  logic [WIDTH-1:0]    lu_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WIDTH-1:0]    res_data,
  output logic [LU_CTL_W-1:0] res_ctl,
`ifdef LU_ISSUE_STATS_EN
  output logic [31:0]         issued_cnt,
  output logic [31:0]         stall_cnt,
`endif
  output logic [CW-1:0]       count
);
  lu_cmd_t             cmd_in, head;
  logic [LU_CMD_W-1:0] head_bits;
  logic                full, empty, push, load;

  logic                res_valid_q, res_valid_d;
  logic [WIDTH-1:0]    res_data_q, res_data_d;
  logic [LU_CTL_W-1:0] res_ctl_q, res_ctl_d;

  assign cmd_in = {cmd_ctl, cmd_a, cmd_b};
  assign head   = lu_cmd_t'(head_bits);

  lu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LU_CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (cmd_in),
    .pop_i   (load),
    .head_o  (head_bits),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Acceptance ignores a same-cycle pop so cmd_ready depends on state only.
  assign cmd_ready = rst_n & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign load      = ~empty & (~res_valid_q | res_ready);

  assign lu_a   = empty ? '0 : head.a;
  assign lu_b   = empty ? '0 : head.b;
  assign lu_ctl = empty ? '0 : head.ctl;

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ctl_d   = res_ctl_q;
    if (load) begin
      res_valid_d = 1'b1;
      res_data_d  = lu_out;
      res_ctl_d   = head.ctl;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ctl_q   <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ctl_q   <= res_ctl_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ctl   = res_ctl_q;

`ifdef LU_ISSUE_STATS_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] stall_q, stall_d;

  // A stall is a result blocked downstream while work waits behind it.
  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (load) issued_d = issued_q + 32'd1;
    if (res_valid_q && !res_ready && !empty) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign issued_cnt = issued_q;
  assign stall_cnt  = stall_q;
`endif
endmodule

// File: tb/tb_lu_issue_queue.sv
// Directed bench for lu_issue_queue with a combinational logic unit closing the lu_* loop.
module tb_lu_issue_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  cmd_ctl;
  logic [31:0] lu_a, lu_b, lu_out;
  logic [2:0]  lu_ctl;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_ctl;
  logic [2:0]  count;
`ifdef LU_ISSUE_STATS_EN
  logic [31:0] issued_cnt, stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lu_issue_queue #(.WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_ctl   (cmd_ctl),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_ctl    (lu_ctl),
    .lu_out    (lu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ctl   (res_ctl),
`ifdef LU_ISSUE_STATS_EN
    .issued_cnt(issued_cnt),
    .stall_cnt (stall_cnt),
`endif
    .count     (count)
  );

  // Logic unit: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 A&~B, 7 ~A
  always_comb begin
    lu_out = '0;
    case (lu_ctl)
      3'd0: lu_out = lu_a & lu_b;
      3'd1: lu_out = lu_a | lu_b;
      3'd2: lu_out = lu_a ^ lu_b;
      3'd3: lu_out = ~(lu_a & lu_b);
      3'd4: lu_out = ~(lu_a | lu_b);
      3'd5: lu_out = ~(lu_a ^ lu_b);
      3'd6: lu_out = lu_a & ~lu_b;
      default: lu_out = ~lu_a;
    endcase
  end

  // Hand-computed results for a = FF00FF00, b = 0FF00FF0 per ctl
  logic [31:0] exp_lu [8] = '{32'h0F000F00, 32'hFFF0FFF0, 32'hF0F0F0F0, 32'hF0FFF0FF,
                              32'h000F000F, 32'h0F0F0F0F, 32'hF000F000, 32'h00FF00FF};
  int exp_cnt4 [5] = '{3, 2, 1, 0, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int exp_id;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_ctl = '0; res_ready = 1'b0;

    // 1. reset
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_lu_a", lu_a, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();

    // 2. single command
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 32'h26; cmd_b = 32'h0; cmd_ctl = 3'b001;
    tick();
    cmd_valid = 1'b0;
    chk("single_lu_a", lu_a, 32'h26);
    chk("single_count", 32'(count), 32'd1);
    chk("single_nores", 32'(res_valid), 32'd0);
    tick();
    chk("single_res_valid", 32'(res_valid), 32'd1);
    chk("single_res_ctl", 32'(res_ctl), 32'd1);
    chk("single_res_data", res_data, 32'h26);
    chk("single_lu_empty", lu_a, 32'd0);
    tick();
    chk("single_pulse_end", 32'(res_valid), 32'd0);
    chk("single_data_hold", res_data, 32'h26);

    // 3. backpressure
    res_ready = 1'b0;
    acc = 0;
    cmd_a = 32'hFF00FF00; cmd_b = 32'h0FF00FF0;
    for (int i = 0; i < 7; i++) begin
      cmd_valid = 1'b1; cmd_ctl = 3'(i);
      #1;
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    chk("bp_res_ctl", 32'(res_ctl), 32'd0);
    chk("bp_res_data", res_data, exp_lu[0]);
    tick(); tick();
    chk("bp_res_ctl_hold", 32'(res_ctl), 32'd0);
    chk("bp_count_hold", 32'(count), 32'd4);

    // 4. drain
    res_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", 32'(res_valid), 32'd1);
      chk("drain_ctl", 32'(res_ctl), 32'(k));
      chk("drain_data", res_data, exp_lu[k]);
      tick();
      chk("drain_count", 32'(count), 32'(exp_cnt4[k]));
    end
    chk("drain_done", 32'(res_valid), 32'd0);
    cmd_valid = 1'b1; cmd_ctl = 3'd5;
    #1 chk("late5_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("late5_count", 32'(count), 32'd1);
    cmd_ctl = 3'd6;
    #1 chk("late6_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("late_pushpop_count", 32'(count), 32'd1);
    chk("late5_res_ctl", 32'(res_ctl), 32'd5);
    chk("late5_res_data", res_data, exp_lu[5]);
    tick();
    chk("late6_res_ctl", 32'(res_ctl), 32'd6);
    chk("late6_res_data", res_data, exp_lu[6]);
    chk("late_count", 32'(count), 32'd0);
    tick();
    chk("late_idle", 32'(res_valid), 32'd0);

    // 5. push/pop at count 2 across 3*DEPTH commands
    res_ready = 1'b0;
    cmd_b = 32'h0;
    for (int id = 0; id < 3; id++) begin
      cmd_valid = 1'b1; cmd_a = 32'(id); cmd_ctl = (id % 2 == 1) ? 3'd2 : 3'd1;
      tick();
    end
    chk("pp_fill_count", 32'(count), 32'd2);
    chk("pp_fill_valid", 32'(res_valid), 32'd1);
    chk("pp_fill_data", res_data, 32'd0);
    res_ready = 1'b1;
    exp_id = 0;
    for (int id = 3; id < 12; id++) begin
      cmd_valid = 1'b1; cmd_a = 32'(id); cmd_ctl = (id % 2 == 1) ? 3'd2 : 3'd1;
      #1;
      chk("pp_count", 32'(count), 32'd2);
      chk("pp_valid", 32'(res_valid), 32'd1);
      chk("pp_data", res_data, 32'(exp_id));
      chk("pp_ctl", 32'(res_ctl), (exp_id % 2 == 1) ? 32'd2 : 32'd1);
      tick();
      exp_id++;
    end
    cmd_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk("pp_tail_valid", 32'(res_valid), 32'd1);
      chk("pp_tail_data", res_data, 32'(exp_id));
      tick();
      exp_id++;
    end
    chk("pp_end_valid", 32'(res_valid), 32'd0);
    chk("pp_end_count", 32'(count), 32'd0);

    // 6. async reset mid-operation
    res_ready = 1'b0;
    cmd_b = 32'h0; cmd_ctl = 3'd1;
    for (int id = 0; id < 4; id++) begin
      cmd_valid = 1'b1; cmd_a = 32'hA0 + 32'(id);
      tick();
    end
    cmd_valid = 1'b0;
    chk("ar_pre_count", 32'(count), 32'd3);
    chk("ar_pre_valid", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_valid", 32'(res_valid), 32'd0);
    chk("ar_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("ar_lu_a", lu_a, 32'd0);
    chk("ar_res_data", res_data, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    res_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("ar_no_stale", 32'(res_valid), 32'd0);
      chk("ar_empty", 32'(count), 32'd0);
    end
    cmd_valid = 1'b1; cmd_a = 32'h55; cmd_b = 32'h0; cmd_ctl = 3'd1;
    tick();
    cmd_valid = 1'b0;
    chk("ar_new_lu_a", lu_a, 32'h55);
    chk("ar_new_not_yet", 32'(res_valid), 32'd0);
    tick();
    chk("ar_new_valid", 32'(res_valid), 32'd1);
    chk("ar_new_data", res_data, 32'h55);
`ifdef LU_ISSUE_STATS_EN
    chk("stats_issued", issued_cnt, 32'd1);
    chk("stats_stall", stall_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lu_issue_queue.md
# lu_issue_queue

Operand issue stage that sits directly upstream of the 32-bit combinational logic unit. It buffers incoming {a, b, ctl} commands in a small FIFO and presents the head command to the logic unit. It captures the logic unit's combinational result into an output register and delivers it downstream over a valid/ready handshake. Results leave in command order, and throughput is one result per cycle.

## Interface
- WIDTH, 32, operand and result width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  command accepted on clk edge when cmd_valid & cmd_ready
- cmd_a  in  WIDTH  operand a
- cmd_b  in  WIDTH  operand b
- cmd_ctl  in  3  logic-unit function select, passed through unmodified
- lu_a  out  WIDTH  to logic unit a
- lu_b  out  WIDTH  to logic unit b
- lu_ctl  out  3  to logic unit ctl
- lu_out  in  WIDTH  logic unit result, combinational from lu_a/lu_b/lu_ctl
- res_valid  out  1  result register holds data
- res_ready  in  1  downstream accepts result
- res_data  out  WIDTH  captured lu_out
- res_ctl  out  3  ctl of the captured command
- count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- Push occurs when cmd_valid & cmd_ready; the entry is written at the FIFO tail.
- cmd_ready = rst_n & (count != DEPTH). Acceptance does not look ahead on same-cycle pops.
- lu_a/lu_b/lu_ctl are driven from the FIFO head when count > 0, and are all-zero when the FIFO is empty.
- Load occurs when count > 0 & (!res_valid | res_ready). On load, res_data <= lu_out, res_ctl <= head ctl, res_valid <= 1, and the head is popped.
- When res_valid & res_ready and there is no load, res_valid <= 0. res_data and res_ctl hold their last value.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- A push into an empty FIFO is not bypassed to the result register. The entry must first become the head.
- Capacity: with res_ready held low, DEPTH+1 commands are in flight (DEPTH in the FIFO, 1 in the result register).
- Ordering: res_data/res_ctl are delivered in strict push order, with no drops or duplicates.

## Timing
- Reset (asynchronous, takes effect immediately):
  - count = 0, pointers = 0, res_valid = 0, res_data = 0, res_ctl = 0
  - lu_* = 0
  - cmd_ready = 0 while rst_n is low
- Latency: a command pushed at edge k is the head after k. It is loaded at edge k+1, provided the result register is free or draining, so res_valid rises after edge k+1.
- Steady state with res_ready = 1: one result per cycle.
- Reset asserted mid-operation discards all FIFO contents and any pending result. No stale result appears after release.
- Outputs are registered except cmd_ready and lu_*, which are combinational from state.

## Configuration
- LU_ISSUE_STATS_EN defined:
  - Adds output issued_cnt [31:0], which increments on each load, wraps at 2^32, and resets to 0.
  - Adds output stall_cnt [31:0], which increments each cycle where res_valid & !res_ready & count > 0, and resets to 0.
- LU_ISSUE_STATS_EN undefined: neither port nor either counter exists. Behaviour is otherwise identical.

## Structure
- Shared package lu_pkg holds:
  - the LU_CTL_W = 3 constant
  - a typedef lu_cmd_t struct {ctl, a, b}, which the FIFO stores
- One sub-module, lu_cmd_fifo: parameterised DEPTH/WIDTH synchronous FIFO.
  - Signals: push, pop, head, count, full, empty.
  - Same clk/rst_n.
- The top level holds the result register, load logic and stats counters.

## Test plan
The bench instantiates the real logic unit between lu_* and lu_out.

1. Reset: hold rst_n low mid-clock.
   - While low: count = 0, res_valid = 0, cmd_ready = 0, lu_a = 0.
   - After release: cmd_ready = 1.
2. Single command: push a = 32'h26, b = 0, ctl = 3'b001 with res_ready = 1.
   - lu_a = 32'h26 after the push edge.
   - res_valid pulses for exactly one cycle, one edge later.
   - res_ctl = 001 and res_data equals the logic-unit output for those operands.
3. Backpressure: res_ready = 0, offer 7 commands with ctl = 000..110.
   - Exactly 5 are accepted.
   - cmd_ready drops after the 5th; count = 4; res_ctl = 000 held stable.
4. Drain: from state 3, raise res_ready.
   - Results stream out one per cycle with res_ctl = 000,001,010,011,100 in order.
   - count reaches 0, then the remaining two offered commands are accepted.
5. Simultaneous push/pop at count = 2 with res_ready = 1: count stays 2 and pointer wrap is exercised across 3×DEPTH commands without reordering.
6. Asynchronous reset asserted with count = 3 and res_valid = 1:
   - count = 0 and res_valid = 0 immediately.
   - No result is delivered after release until a new push.
